preenche_buffer: RTL and testbench
==================================

// Module: preenche_buffer
// PURPOSE
//  Parametrised frame-buffer fill engine; next generation of the clear sweep.
//  Generates raster-order (x,y) write addresses plus a fill colour for the video RAM.
//  Either clears the whole frame or fills a clamped rectangle.
//  Sits between the drawing control FSM and the frame-buffer write port.
//  Start/done handshake; honours write-port backpressure (wr_ready).
// PARAMETERS
//  H_RES    320  visible columns; x range 0..H_RES-1
//  V_RES    240  visible lines; y range 0..V_RES-1
//  COORD_W  11   width of every coordinate port
//  COLOR_W  12   width of fill colour / write data
// PORTS
//  clock       in   1        system clock, rising edge
//  reset       in   1        asynchronous, active-high; clears all state
//  start       in   1        request fill; sampled only in IDLE
//  mode        in   1        0 = full frame, 1 = rectangle (x0,y0)-(x1,y1) inclusive
//  x0, y0      in   COORD_W  rectangle top-left corner (mode 1)
//  x1, y1      in   COORD_W  rectangle bottom-right corner (mode 1)
//  fill_color  in   COLOR_W  colour written to every pixel
//  abort       in   1        stop current fill; return to IDLE without done
//  wr_ready    in   1        write port accepts wr_data this cycle
//  x_coord     out  COORD_W  current write column
//  y_coord     out  COORD_W  current write line
//  wr_data     out  COLOR_W  latched fill colour
//  wr_en       out  1        write request (zera_buffer equivalent)
//  busy        out  1        high whenever state != IDLE
//  done        out  1        one-cycle pulse after the last accepted write
// BEHAVIOUR
//  Reset (async): state=IDLE; x_coord, y_coord, wr_data, wr_en, busy, done all 0.
//  States: IDLE -> FILL -> DONE -> IDLE; IDLE -> DONE (empty region).
//  IDLE: start=1 at edge N latches mode, fill_color and bounds:
//   mode 0: bounds (0,0)-(H_RES-1,V_RES-1).
//   mode 1: x1 clamped to H_RES-1, y1 to V_RES-1; x0/y0 unclamped.
//   Region empty (x0>x1 or y0>y1 after clamp): go to DONE at N+1, zero writes.
//   Otherwise FILL at N+1 with x_coord=x0, y_coord=y0, wr_en=1.
//  FILL: wr_en=1 every cycle; transfer = wr_en & wr_ready.
//   No transfer: x_coord, y_coord, wr_data held stable.
//   Transfer, x<x1: x+1. Transfer, x==x1, y<y1: x=x0, y+1.
//   Transfer at (x1,y1): wr_en=0, go to DONE next edge.
//   Exactly (x1-x0+1)*(y1-y0+1) transfers, raster order, no repeats, no gaps.
//  DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
//  start while busy: ignored (not queued). abort priority over transfer.
//  abort in FILL or DONE: IDLE next edge, wr_en=0, done stays 0; coords hold.
//  abort and start together in IDLE: start ignored.
//  Coordinates never exceed H_RES-1 / V_RES-1; arithmetic in COORD_W bits, no wrap.
//  Reset mid-fill: immediate return to reset values; no done pulse.
// TESTING
//  1 mode0, wr_ready=1, start pulse -> 76800 writes (0,0)..(319,239), done 76801 cyc after start edge.
//  2 mode1 (10,20)-(12,21), color 0xABC -> 6 writes (10,20)(11,20)(12,20)(10,21)(11,21)(12,21), data 0xABC, one done.
//  3 test 2 with wr_ready toggling 1,0,0,1,... -> same 6 writes; coords/data stable while ready=0.
//  4 mode1 (5,5)-(4,9) -> wr_en never high; done pulses at start edge+1; busy 1 cycle.
//  5 mode1 (318,238)-(500,400) -> clamped: 4 writes (318..319 x 238..239), done once.
//  6 abort after 100 writes, then reset mid-second fill -> IDLE, no done; all outputs 0 async.

Source files
------------

// File: rtl/preenche_buffer_if.sv
// rtl/preenche_buffer_if.sv - fill request, write-port handshake and status bundle
interface preenche_buffer_if #(
    parameter int COORD_W = 11,
    parameter int COLOR_W = 12
);
    logic               start;
    logic               mode;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COLOR_W-1:0] fill_color;
    logic               abort;
    logic               wr_ready;
    logic [COORD_W-1:0] x_coord;
    logic [COORD_W-1:0] y_coord;
    logic [COLOR_W-1:0] wr_data;
    logic               wr_en;
    logic               busy;
    logic               done;

    modport master (
        output start, mode, x0, y0, x1, y1, fill_color, abort, wr_ready,
        input  x_coord, y_coord, wr_data, wr_en, busy, done
    );

    modport slave (
        input  start, mode, x0, y0, x1, y1, fill_color, abort, wr_ready,
        output x_coord, y_coord, wr_data, wr_en, busy, done
    );
endinterface

// File: rtl/preenche_buffer.sv
// rtl/preenche_buffer.sv - raster-order frame/rectangle fill address generator
module preenche_buffer #(
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int COORD_W = 11,
    parameter int COLOR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    preenche_buffer_if.slave  bus
);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t             state, state_next;
    logic [COORD_W-1:0] x_cur, y_cur;
    logic [COORD_W-1:0] x_start, x_end, y_end;
    logic [COLOR_W-1:0] color_q;

    logic [COORD_W-1:0] req_x0, req_y0, req_x1, req_y1;
    logic               req_empty, accept, xfer, at_x_end, at_last;

    // Only the far corner is clamped; an off-screen near corner makes the region empty.
    always_comb begin
        req_x0    = bus.mode ? bus.x0 : '0;
        req_y0    = bus.mode ? bus.y0 : '0;
        req_x1    = (bus.mode && bus.x1 <= X_MAX) ? bus.x1 : X_MAX;
        req_y1    = (bus.mode && bus.y1 <= Y_MAX) ? bus.y1 : Y_MAX;
        req_empty = (req_x0 > req_x1) || (req_y0 > req_y1);
        accept    = (state == S_IDLE) && bus.start && !bus.abort;
        xfer      = (state == S_FILL) && bus.wr_ready && !bus.abort;
        at_x_end  = (x_cur == x_end);
        at_last   = at_x_end && (y_cur == y_end);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = req_empty ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (bus.abort) begin
                    state_next = S_IDLE;
                end else if (xfer && at_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_cur   <= '0;
            y_cur   <= '0;
            x_start <= '0;
            x_end   <= '0;
            y_end   <= '0;
            color_q <= '0;
        end else if (accept) begin
            color_q <= bus.fill_color;
            // Coordinates stay untouched for an empty region so they never leave the screen.
            if (!req_empty) begin
                x_cur   <= req_x0;
                y_cur   <= req_y0;
                x_start <= req_x0;
                x_end   <= req_x1;
                y_end   <= req_y1;
            end
        end else if (xfer && !at_last) begin
            if (at_x_end) begin
                x_cur <= x_start;
                y_cur <= y_cur + COORD_W'(1);
            end else begin
                x_cur <= x_cur + COORD_W'(1);
            end
        end
    end

    always_comb begin
        bus.wr_en   = (state == S_FILL);
        bus.busy    = (state != S_IDLE);
        bus.done    = (state == S_DONE);
        bus.x_coord = x_cur;
        bus.y_coord = y_cur;
        bus.wr_data = color_q;
    end
endmodule

// File: tb/tb_preenche_buffer.sv
// tb/tb_preenche_buffer.sv - directed self-checking bench for preenche_buffer
module tb_preenche_buffer;
    logic clock = 1'b0;
    logic reset = 1'b0;

    preenche_buffer_if bus ();

    preenche_buffer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    int tx_x[$];
    int tx_y[$];
    int tx_d[$];
    int done_cnt, done_cyc, busy_cnt, wren_cnt, stable_bad;
    bit timed_out;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drives one request and records every accepted write; k counts edges after the drive edge.
    task automatic run_fill(input logic m, input int ax0, input int ay0, input int ax1, input int ay1,
                            input logic [11:0] col, input bit toggle, input int budget);
        int k = 0;
        int p = 0;
        bit hold_pend = 0;
        int px = 0, py = 0, pd = 0;
        bit rdy;
        tx_x.delete(); tx_y.delete(); tx_d.delete();
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; wren_cnt = 0; stable_bad = 0; timed_out = 0;
        bus.mode = m;
        bus.x0 = 11'(ax0); bus.y0 = 11'(ay0);
        bus.x1 = 11'(ax1); bus.y1 = 11'(ay1);
        bus.fill_color = col;
        bus.wr_ready = 1'b1;
        bus.start = 1'b1;
        while (1) begin
            step();
            k++;
            bus.start = 1'b0;
            if (hold_pend) begin
                if (int'(bus.x_coord) != px || int'(bus.y_coord) != py || int'(bus.wr_data) != pd)
                    stable_bad++;
                hold_pend = 0;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = k;
            end
            if (!bus.busy) break;
            busy_cnt++;
            if (k > budget) begin
                timed_out = 1;
                break;
            end
            if (bus.wr_en) begin
                wren_cnt++;
                rdy = toggle ? (p % 3 == 0) : 1'b1;
                p++;
                bus.wr_ready = rdy;
                if (rdy) begin
                    tx_x.push_back(int'(bus.x_coord));
                    tx_y.push_back(int'(bus.y_coord));
                    tx_d.push_back(int'(bus.wr_data));
                end else begin
                    hold_pend = 1;
                    px = int'(bus.x_coord); py = int'(bus.y_coord); pd = int'(bus.wr_data);
                end
            end
        end
        bus.wr_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.x_coord, bus.y_coord, bus.wr_data, bus.wr_en, bus.busy, bus.done} !== 37'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got x=%0d y=%0d d=%h en=%b busy=%b done=%b, want all 0",
                     bus.x_coord, bus.y_coord, bus.wr_data, bus.wr_en, bus.busy, bus.done);
        end
        step(); step();
        reset = 1'b0;
        step();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_idle: got busy=%b en=%b, want 0 0", bus.busy, bus.wr_en);
        end
    endtask

    task automatic test_rect();
        int i = 0;
        int shown = 0;
        run_fill(1'b1, 10, 20, 12, 21, 12'hABC, 1'b0, 100);
        n_cmp++;
        if (tx_x.size() != 6) begin
            n_bad++;
            $display("FAIL rect_count: got %0d writes, want 6", tx_x.size());
        end
        for (int y = 20; y <= 21; y++) begin
            for (int x = 10; x <= 12; x++) begin
                n_cmp++;
                if (i >= tx_x.size() || tx_x[i] != x || tx_y[i] != y || tx_d[i] != 'hABC) begin
                    n_bad++;
                    if (shown < 8)
                        $display("FAIL rect_write[%0d]: got (%0d,%0d,%h), want (%0d,%0d,abc)", i,
                                 (i < tx_x.size()) ? tx_x[i] : -1, (i < tx_y.size()) ? tx_y[i] : -1,
                                 (i < tx_d.size()) ? tx_d[i] : -1, x, y);
                    shown++;
                end
                i++;
            end
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != 7 || timed_out) begin
            n_bad++;
            $display("FAIL rect_done: got count=%0d cycle=%0d timeout=%0d, want 1 7 0", done_cnt, done_cyc, timed_out);
        end
    endtask

    task automatic test_backpressure();
        int i = 0;
        int shown = 0;
        run_fill(1'b1, 10, 20, 12, 21, 12'hABC, 1'b1, 200);
        n_cmp++;
        if (tx_x.size() != 6) begin
            n_bad++;
            $display("FAIL bp_count: got %0d writes, want 6", tx_x.size());
        end
        for (int y = 20; y <= 21; y++) begin
            for (int x = 10; x <= 12; x++) begin
                n_cmp++;
                if (i >= tx_x.size() || tx_x[i] != x || tx_y[i] != y || tx_d[i] != 'hABC) begin
                    n_bad++;
                    if (shown < 8)
                        $display("FAIL bp_write[%0d]: got (%0d,%0d), want (%0d,%0d)", i,
                                 (i < tx_x.size()) ? tx_x[i] : -1, (i < tx_y.size()) ? tx_y[i] : -1, x, y);
                    shown++;
                end
                i++;
            end
        end
        n_cmp++;
        if (stable_bad != 0) begin
            n_bad++;
            $display("FAIL bp_hold_stable: got %0d unstable stalls, want 0", stable_bad);
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != 17 || wren_cnt != 16) begin
            n_bad++;
            $display("FAIL bp_done: got count=%0d cycle=%0d en_cycles=%0d, want 1 17 16", done_cnt, done_cyc, wren_cnt);
        end
    endtask

    task automatic test_empty();
        run_fill(1'b1, 5, 5, 4, 9, 12'h111, 1'b0, 50);
        n_cmp++;
        if (wren_cnt != 0 || tx_x.size() != 0) begin
            n_bad++;
            $display("FAIL empty_no_writes: got en_cycles=%0d writes=%0d, want 0 0", wren_cnt, tx_x.size());
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != 1 || busy_cnt != 1) begin
            n_bad++;
            $display("FAIL empty_done: got count=%0d cycle=%0d busy=%0d, want 1 1 1", done_cnt, done_cyc, busy_cnt);
        end
    endtask

    task automatic test_clamp();
        int ex[4] = '{318, 319, 318, 319};
        int ey[4] = '{238, 238, 239, 239};
        run_fill(1'b1, 318, 238, 500, 400, 12'hF0F, 1'b0, 50);
        n_cmp++;
        if (tx_x.size() != 4) begin
            n_bad++;
            $display("FAIL clamp_count: got %0d writes, want 4", tx_x.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= tx_x.size() || tx_x[i] != ex[i] || tx_y[i] != ey[i] || tx_d[i] != 'hF0F) begin
                n_bad++;
                $display("FAIL clamp_write[%0d]: got (%0d,%0d), want (%0d,%0d)", i,
                         (i < tx_x.size()) ? tx_x[i] : -1, (i < tx_y.size()) ? tx_y[i] : -1, ex[i], ey[i]);
            end
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != 5) begin
            n_bad++;
            $display("FAIL clamp_done: got count=%0d cycle=%0d, want 1 5", done_cnt, done_cyc);
        end
    endtask

    task automatic test_full_frame();
        int i = 0;
        int shown = 0;
        run_fill(1'b0, 7, 7, 3, 3, 12'h0F0, 1'b0, 77000);
        n_cmp++;
        if (tx_x.size() != 76800) begin
            n_bad++;
            $display("FAIL full_count: got %0d writes, want 76800", tx_x.size());
        end
        for (int y = 0; y < 240; y++) begin
            for (int x = 0; x < 320; x++) begin
                n_cmp++;
                if (i >= tx_x.size() || tx_x[i] != x || tx_y[i] != y || tx_d[i] != 'h0F0) begin
                    n_bad++;
                    if (shown < 8)
                        $display("FAIL full_write[%0d]: got (%0d,%0d), want (%0d,%0d)", i,
                                 (i < tx_x.size()) ? tx_x[i] : -1, (i < tx_y.size()) ? tx_y[i] : -1, x, y);
                    shown++;
                end
                i++;
            end
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != 76801 || timed_out) begin
            n_bad++;
            $display("FAIL full_done: got count=%0d cycle=%0d timeout=%0d, want 1 76801 0", done_cnt, done_cyc, timed_out);
        end
    endtask

    task automatic test_abort_reset();
        int done_seen = 0;
        bus.mode = 1'b0;
        bus.fill_color = 12'h123;
        bus.wr_ready = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            bus.start = (k == 50);
            step();
            if (bus.done) done_seen++;
        end
        bus.start = 1'b0;
        n_cmp++;
        if (bus.x_coord !== 11'd100 || bus.y_coord !== 11'd0 || bus.busy !== 1'b1 || bus.wr_en !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_before: got x=%0d y=%0d busy=%b en=%b, want 100 0 1 1",
                     bus.x_coord, bus.y_coord, bus.busy, bus.wr_en);
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0 || bus.done !== 1'b0 || bus.x_coord !== 11'd100) begin
            n_bad++;
            $display("FAIL abort_idle: got busy=%b en=%b done=%b x=%0d, want 0 0 0 100",
                     bus.busy, bus.wr_en, bus.done, bus.x_coord);
        end
        repeat (3) begin
            step();
            if (bus.done || bus.busy) done_seen++;
        end
        n_cmp++;
        if (done_seen != 0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d done/busy cycles, want 0", done_seen);
        end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_start_idle: got busy=%b, want 0", bus.busy);
        end
        bus.mode = 1'b1;
        bus.x0 = 11'd0; bus.y0 = 11'd0; bus.x1 = 11'd319; bus.y1 = 11'd239;
        bus.fill_color = 12'h5A5;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (20) step();
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.wr_data !== 12'h5A5 || bus.x_coord !== 11'd20 || bus.y_coord !== 11'd0) begin
            n_bad++;
            $display("FAIL second_fill: got busy=%b d=%h x=%0d y=%0d, want 1 5a5 20 0",
                     bus.busy, bus.wr_data, bus.x_coord, bus.y_coord);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.x_coord, bus.y_coord, bus.wr_data, bus.wr_en, bus.busy, bus.done} !== 37'd0) begin
            n_bad++;
            $display("FAIL reset_mid_fill: got x=%0d y=%0d d=%h en=%b busy=%b done=%b, want all 0",
                     bus.x_coord, bus.y_coord, bus.wr_data, bus.wr_en, bus.busy, bus.done);
        end
        step(); step();
        reset = 1'b0;
        done_seen = 0;
        repeat (4) begin
            step();
            if (bus.done || bus.busy || bus.wr_en) done_seen++;
        end
        n_cmp++;
        if (done_seen != 0) begin
            n_bad++;
            $display("FAIL reset_stays_idle: got %0d active cycles, want 0", done_seen);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        bus.fill_color = '0;
        bus.abort = 1'b0;
        bus.wr_ready = 1'b1;
        test_reset();
        test_rect();
        test_backpressure();
        test_empty();
        test_clamp();
        test_full_frame();
        test_abort_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
